// File: rtl/px_out_fifo_if.sv
// Pixel handshake bundle between the processing core, the output FIFO and the SPI reader.
// The slave modport is the FIFO side; the master modport drives it.
interface px_out_fifo_if #(
  parameter int PIXEL_W = 8,
  parameter int DEPTH   = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               px_rdy_i;
  logic [PIXEL_W-1:0] px_i;
  logic               flush_i;
  logic               px_valid_o;
  logic [PIXEL_W-1:0] px_o;
  logic               px_ready_i;
  logic [CNT_W-1:0]   count_o;
  logic               full_o;
  logic               overflow_o;

  modport slave (
    input  px_rdy_i, px_i, flush_i, px_ready_i,
    output px_valid_o, px_o, count_o, full_o, overflow_o
  );

  modport master (
    output px_rdy_i, px_i, flush_i, px_ready_i,
    input  px_valid_o, px_o, count_o, full_o, overflow_o
  );
endinterface

// File: rtl/px_out_fifo.sv
// Output-pixel elastic buffer: circular FIFO with show-ahead valid/ready read side,
// sticky overflow on dropped pushes and a synchronous flush.
module px_out_fifo #(
  parameter int PIXEL_W = 8,
  parameter int DEPTH   = 8
) (
  input  logic          clk_i,
  input  logic          nreset_i,
  px_out_fifo_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  logic [PIXEL_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               overflow;
  logic               full;
  logic               valid;
  logic               push;
  logic               pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign valid = (count != '0);
  assign pop   = valid & bus.px_ready_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push  = bus.px_rdy_i & (~full | pop);

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (bus.flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is the natural rollover.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (bus.px_rdy_i && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !bus.flush_i) mem[wr_ptr] <= bus.px_i;
  end

  assign bus.px_valid_o = valid;
  // Gate the head so an empty or reset FIFO never shows stale memory.
  assign bus.px_o       = valid ? mem[rd_ptr] : '0;
  assign bus.count_o    = count;
  assign bus.full_o     = full;
  assign bus.overflow_o = overflow;
endmodule
